// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, signed/unsigned, 32-bit operands.
// Result is {remainder, quotient}, presented for one cycle with ready_o.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  output logic        ready_o,
  output logic [63:0] result_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [64:0] pr;
  logic [31:0] divisor;
  logic        q_neg;
  logic        r_neg;
  logic [63:0] res_q;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [64:0] sh;
  logic [32:0] diff;
  logic        ge;
  logic [64:0] pr_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  assign a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1)
                                                 : opdata1_i;
  assign b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1)
                                                 : opdata2_i;

  assign sh    = {pr[63:0], 1'b0};
  assign diff  = sh[64:32] - {1'b0, divisor};
  assign ge    = sh[64:32] >= {1'b0, divisor};
  assign pr_nx = ge ? {diff, sh[31:1], 1'b1} : sh;

  assign q_fin = q_neg ? (~pr_nx[31:0] + 32'd1) : pr_nx[31:0];
  assign r_fin = r_neg ? (~pr_nx[63:32] + 32'd1) : pr_nx[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      pr       <= 65'd0;
      divisor  <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      res_q    <= 64'd0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      ready_o  <= 1'b0;
      result_o <= 64'd0;
      if (annul_i || flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i) begin
              cnt     <= 5'd0;
              pr      <= {33'd0, a_abs};
              divisor <= b_abs;
              q_neg   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              r_neg   <= signed_div_i & opdata1_i[31];
              state   <= (opdata2_i == 32'd0) ? DIVZERO : BUSY;
            end
          end
          DIVZERO: begin
            res_q <= 64'd0;
            state <= DONE;
          end
          BUSY: begin
            pr  <= pr_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              res_q <= {r_fin, q_fin};
              state <= DONE;
            end
          end
          DONE: begin
            ready_o  <= 1'b1;
            result_o <= res_q;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed vector table, corner sequences,
// and random operations checked against an arithmetic model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic        ready_o;
  logic [63:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i),
    .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn,
      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Counts edges until ready_o is seen; lat=99 if it never comes.
  task automatic wait_ready(output logic [63:0] r, output int lat,
                            output logic zero_ok);
    bit seen = 0;
    lat = 0;
    r = '0;
    zero_ok = 1'b1;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (ready_o) begin
        seen = 1;
        r = result_o;
      end else if (result_o !== 64'd0) begin
        zero_ok = 1'b0;
      end
    end
    if (!seen) lat = 99;
  endtask

  task automatic run_op(input string name, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    logic [63:0] r;
    int          lat;
    logic        z;
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sgn;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = ~sgn;
    wait_ready(r, lat, z);
    chk({name, "_res"}, r, exp);
    chk({name, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    chk({name, "_zero"}, {63'd0, z}, 64'd1);
    @(posedge clk); #1;
    chk({name, "_pulse"}, {63'd0, ready_o}, 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [63:0] r;
    int          lat;
    logic        z;
    int          seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        64'h00000000_FFFFFFFF};
    vecs[4] = '{1'b0, 32'd5,          32'd0,        64'h0};
    vecs[5] = '{1'b0, 32'd9,          32'd3,        64'h00000000_00000003};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 64'hFFFFFFFF_00000003};
    vecs[8] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        64'h00000001_7FFFFFFC};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a,
             vecs[i].b, vecs[i].exp);

    // Annul during iteration 10, then no delivery for 40 cycles.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o || result_o != 64'd0) seen++;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Annul together with start in IDLE keeps the block idle.
    start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("annul_start_idle", 64'(seen), 64'd0);

    // Flush mid-operation also discards the result.
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    chk("flush_quiet", 64'(seen), 64'd0);

    // Reset at iteration 20 with start held, then a fresh operation.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    opdata1_i = 32'd1; opdata2_i = 32'd1;
    wait_ready(r, lat, z);
    start_i = 1'b0;
    chk("rst_restart_res", r, 64'h00000002_0000000E);
    chk("rst_restart_lat", 64'(lat), 64'd33);

    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      logic        sg;
      logic [31:0] a, b;
      int          k;
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      k  = $urandom_range(0, 5);
      b  = (k == 0) ? 32'd0 :
           (k == 1) ? 32'hFFFF_FFFF :
           (k <= 3) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op($sformatf("rnd%0d", i), sg, a, b, ref_div(sg, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  pipeline flush; aborts any operation.
REQ-004 opdata1_i  input  32  dividend.
REQ-005 opdata2_i  input  32  divisor.
REQ-006 start_i  input  1  request; held high by the requester until it sees ready_o.
REQ-007 annul_i  input  1  cancel the current operation.
REQ-008 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-009 ready_o  output  1  result-valid pulse.
REQ-010 result_o  output  64  {remainder[31:0], quotient[31:0]}; the remainder is the HI word and the quotient is the LO word.

Function
REQ-011 The block SHALL implement a four-state FSM: IDLE, DIVZERO, BUSY, DONE.
REQ-012 In IDLE with start_i=1, annul_i=0 and flush=0, the block SHALL latch opdata1_i, opdata2_i and signed_div_i.
REQ-013 From that IDLE request, the FSM SHALL go to DIVZERO when opdata2_i==0, else to BUSY with iteration count 0.
REQ-014 On entry to BUSY in signed mode, the operands SHALL be replaced by their absolute values (two's-complement negate if bit 31 set).
REQ-015 On entry to BUSY, the quotient sign SHALL be set to a[31]^b[31] and the remainder sign to a[31]; in unsigned mode both signs SHALL be 0.
REQ-016 BUSY SHALL run a radix-2 restoring divide, one bit per cycle, over a 65-bit partial-remainder/quotient register.
REQ-017 Each BUSY iteration SHALL shift the register left 1, compare the upper 33 bits against {1'b0, |divisor|}, and on >= subtract and set the quotient LSB to 1.
REQ-018 After exactly 32 BUSY cycles (count 0..31), the FSM SHALL go to DONE.
REQ-019 On the transition to DONE, the quotient SHALL be negated if the quotient sign is set, and the remainder SHALL be negated if the remainder sign is set.
REQ-020 DIVZERO SHALL last one cycle, then go to DONE with result 64'h0.
REQ-021 DONE SHALL last exactly one cycle with ready_o=1 and result_o valid, then go to IDLE unconditionally.
REQ-022 ready_o and result_o SHALL be registered outputs.
REQ-023 result_o SHALL be 64'h0 in every state except DONE.
REQ-024 Latency: if start is sampled at edge E, ready_o SHALL be high in the cycle after edge E+33 for a normal divide, and after edge E+2 for divide-by-zero.
REQ-025 Changes to opdata1_i, opdata2_i or signed_div_i after the start edge SHALL NOT affect the result.
REQ-026 The state of start_i during BUSY and DONE SHALL be ignored.
REQ-027 A start_i still high in IDLE after DONE SHALL begin a new operation.
REQ-028 annul_i=1 or flush=1 in any state SHALL force the FSM to IDLE at the next edge with ready_o=0 and no result delivered.
REQ-029 When annul_i/flush and start_i are high together in IDLE, the FSM SHALL stay in IDLE.
REQ-030 Signed overflow: 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wraps, no flag).
REQ-031 Arithmetic SHALL be modulo 2^32 per word.
REQ-032 Signed results SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.

Reset
REQ-033 With rst=1 at an edge, the FSM SHALL go to IDLE.
REQ-034 With rst=1 at an edge, ready_o SHALL be 0, result_o SHALL be 64'h0, and the iteration count and internal registers SHALL clear.
REQ-035 Reset SHALL take precedence over start_i, annul_i and flush.
REQ-036 Reset asserted mid-BUSY SHALL discard the operation; no ready_o SHALL follow.

Verification
REQ-037 Unsigned 100/7 -> ready_o at edge E+34, result_o=64'h00000002_0000000E, ready_o high exactly 1 cycle.
REQ-038 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000.
REQ-039 Unsigned 0xFFFFFFFF/0x00000001 -> 64'h00000000_FFFFFFFF; unsigned 5/0 -> ready_o after 2 edges, result_o=64'h0.
REQ-040 annul_i pulsed at BUSY iteration 10 -> IDLE next cycle, no ready_o for 40 cycles; a following 9/3 yields 64'h00000000_00000003.
REQ-041 rst at BUSY iteration 20 with start_i held high -> IDLE, outputs 0.
REQ-042 After the rst in REQ-041 releases with start_i still high -> a fresh 34-edge operation with the correct result.
